ioctl_dl_tx: RTL
================

Name: ioctl_dl_tx

Overview:
- Transmitter end of the HPS ioctl download interface.
- Replays a byte stream, supplied over valid/ready, as ioctl_download / ioctl_wr / ioctl_addr / ioctl_dout cycles with the same timing shape the framework loader produces.
- Feeds the game's dn_addr/dn_data/dn_wr port from an internal image source, such as a cached ROM image, a self-reload after language change, or a simulation image player.
- Sits beside the framework I/O block in the 25 MHz domain, muxed onto the download bus.

Parameters:
- ADDR_W, 16: ioctl_addr width, matching the game's dn_addr.
- LEAD_CYC, 8: cycles ioctl_download is high before the first write strobe (minimum 1).
- GAP_CYC, 3: idle cycles after each write strobe before the next fetch (minimum 0).
- TAIL_CYC, 8: cycles ioctl_download stays high after the last strobe (minimum 1).

Ports:
- clk_25, in, 1: sole clock.
- RESET_L, in, 1: synchronous reset, active-low.
- start, in, 1: one-cycle request to begin a transfer; sampled only in IDLE.
- abort, in, 1: terminate the transfer early; sampled in LEAD, FETCH and GAP.
- len, in, ADDR_W+1: byte count, latched at start; 0 to 2^ADDR_W.
- src_valid, in, 1: source byte available.
- src_data, in, 8: source byte.
- src_ready, out, 1: block accepts a byte this cycle.
- ioctl_download, out, 1: download window active.
- ioctl_wr, out, 1: single-cycle write strobe.
- ioctl_addr, out, ADDR_W: byte address; valid while ioctl_wr is high.
- ioctl_dout, out, 8: byte data; valid while ioctl_wr is high.
- busy, out, 1: high in any state other than IDLE.
- done, out, 1: one-cycle pulse at the end of a transfer.
- aborted, out, 1: sticky flag; set when the last transfer ended via abort, cleared by the next accepted start.

Behaviour:
- Reset (RESET_L=0 at a clk_25 edge):
  - State goes to IDLE.
  - src_ready, ioctl_download, ioctl_wr, busy, done and aborted are all 0.
  - ioctl_addr and ioctl_dout are 0; the byte counter is 0.
  - Reset in the middle of a transfer drops every output at that same edge. No tail window is produced.
- States: IDLE, LEAD, FETCH, STROBE, GAP, TAIL.
- IDLE:
  - start=1 with len=0: stay in IDLE, pulse done on the next cycle, ioctl_download never rises.
  - start=1 with len>0: latch len, clear the counter and aborted, go to LEAD. ioctl_download goes high on the cycle after start.
- LEAD: count LEAD_CYC cycles, then go to FETCH.
- FETCH:
  - src_ready=1 only in this state, combinational on the state.
  - On src_valid&src_ready: register src_data into ioctl_dout and the counter into ioctl_addr, then go to STROBE.
  - Latency: ioctl_wr is high exactly one cycle after the accepting edge.
  - src_valid may stay low indefinitely; there is no timeout.
- STROBE:
  - ioctl_wr=1 for exactly one cycle; the counter increments.
  - If counter+1 == len, go to TAIL; otherwise go to GAP. GAP_CYC=0 goes straight to FETCH.
  - abort is not sampled here; the strobe always completes.
- GAP: count GAP_CYC cycles, then go to FETCH.
- Between strobes:
  - ioctl_addr and ioctl_dout hold their last values.
  - Consecutive strobes are at least GAP_CYC+2 cycles apart, reached when src_valid is held high.
- Abort: abort=1 in LEAD, FETCH or GAP goes to TAIL on the next edge and sets aborted. In FETCH, abort takes priority over byte acceptance that cycle: no byte is accepted and src_ready is ignored.
- TAIL:
  - ioctl_download stays high for TAIL_CYC cycles, then falls.
  - State goes to IDLE with done=1 for one cycle. This is the first IDLE cycle; busy=0 on that cycle.
- start outside IDLE is ignored.
- len=2^ADDR_W: the last address is 2^ADDR_W−1. The counter is ADDR_W+1 bits wide, so there is no wrap before completion.
- ioctl_addr is always the low ADDR_W bits of the counter at the accepting edge.

Decomposition:
- Shared package ioctl_pkg:
  - State enum ioctl_tx_state_t.
  - Default timing constants IOCTL_LEAD_CYC, IOCTL_GAP_CYC, IOCTL_TAIL_CYC.
  - Download index constants used by the game top.
- One sub-module, ioctl_dl_timer: a loadable down-counter with a zero flag. It is shared by LEAD, GAP and TAIL, loaded with the parameter minus 1 on state entry.
- FSM, byte counter and output registers live in ioctl_dl_tx.

Test Plan:
- Reset values: RESET_L=0 for 2 cycles → all outputs 0 and busy=0. Release, no start → outputs unchanged for 20 cycles.
- Basic transfer: len=4, src_valid held 1 with data 0xA0..0xA3, defaults → ioctl_download rises 1 cycle after start. First ioctl_wr comes 10 cycles after start (1 + LEAD 8 + 1 accept), then repeats every 5 cycles. addr/dout pairs are 0/A0, 1/A1, 2/A2, 3/A3. ioctl_download falls 8 cycles after the last strobe; done pulses once; aborted=0.
- Source stall: len=2, src_valid low for 37 cycles in FETCH → no strobe and src_ready held 1 throughout. Strobe follows 1 cycle after src_valid rises; ioctl_addr holds 0 during the stall.
- Abort: len=100, abort pulsed in GAP after strobe at addr 5 → no further strobes, TAIL of 8 cycles, done pulses, aborted=1. A following start with len=1 clears aborted.
- Boundaries:
  - len=0 → done 1 cycle later, ioctl_download stays 0.
  - ADDR_W=4, len=16 → final strobe at addr 0xF, exactly 16 strobes.
  - start during busy → no effect.
- Reset mid-transfer: RESET_L=0 in the cycle after the 3rd strobe → ioctl_download=0 and busy=0 at that edge, with no done pulse.

Source files
------------

// File: rtl/ioctl_pkg.sv
// Shared types and constants for the HPS ioctl download path.
package ioctl_pkg;

  // Transmitter FSM states.
  typedef enum logic [2:0] {
    StIdle,
    StLead,
    StFetch,
    StStrobe,
    StGap,
    StTail
  } ioctl_tx_state_t;

  // Default window timing, shaped like the framework loader's downloads.
  localparam int unsigned IOCTL_LEAD_CYC = 8;
  localparam int unsigned IOCTL_GAP_CYC  = 3;
  localparam int unsigned IOCTL_TAIL_CYC = 8;

  // Download indices the game top decodes from ioctl_index.
  localparam logic [7:0] IOCTL_IDX_ROM   = 8'd0;
  localparam logic [7:0] IOCTL_IDX_MOD   = 8'd1;
  localparam logic [7:0] IOCTL_IDX_NVRAM = 8'd2;
  localparam logic [7:0] IOCTL_IDX_CFG   = 8'd254;

  // Bits needed to hold a timer load of max_cyc-1 (never less than 1).
  function automatic int unsigned tmr_width(input int unsigned max_cyc);
    return (max_cyc > 1) ? $clog2(max_cyc) : 1;
  endfunction

endpackage

// File: rtl/ioctl_dl_timer.sv
// Loadable down-counter with a zero flag; shared by the LEAD, GAP and TAIL windows.
module ioctl_dl_timer #(
  parameter int unsigned Width = 3
) (
  input  logic             clk_25,
  input  logic             RESET_L,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  output logic             zero_o
);

  localparam logic [Width-1:0] One = Width'(1);

  logic [Width-1:0] cnt_q, cnt_d;

  // Load wins over counting; the counter parks at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - One;
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk_25) begin
    if (!RESET_L) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/ioctl_dl_tx.sv
// Transmitter end of the ioctl download bus: replays a valid/ready byte stream
// as ioctl_download / ioctl_wr / ioctl_addr / ioctl_dout cycles.
module ioctl_dl_tx
  import ioctl_pkg::*;
#(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned LEAD_CYC = IOCTL_LEAD_CYC,
  parameter int unsigned GAP_CYC  = IOCTL_GAP_CYC,
  parameter int unsigned TAIL_CYC = IOCTL_TAIL_CYC
) (
  input  logic              clk_25,
  input  logic              RESET_L,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W:0]   len,
  input  logic              src_valid,
  input  logic [7:0]        src_data,
  output logic              src_ready,
  output logic              ioctl_download,
  output logic              ioctl_wr,
  output logic [ADDR_W-1:0] ioctl_addr,
  output logic [7:0]        ioctl_dout,
  output logic              busy,
  output logic              done,
  output logic              aborted
);

  localparam int unsigned LG_MAX  = (LEAD_CYC > GAP_CYC) ? LEAD_CYC : GAP_CYC;
  localparam int unsigned TMR_MAX = (LG_MAX > TAIL_CYC) ? LG_MAX : TAIL_CYC;
  localparam int unsigned TMR_W   = tmr_width(TMR_MAX);

  // Timer loads are cycles-1 so the zero flag marks the last cycle of a window.
  localparam logic [TMR_W-1:0] LEAD_LOAD = TMR_W'(LEAD_CYC - 1);
  localparam logic [TMR_W-1:0] GAP_LOAD  = TMR_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [TMR_W-1:0] TAIL_LOAD = TMR_W'(TAIL_CYC - 1);

  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W + 1)'(1);

  ioctl_tx_state_t state_q, state_d;

  // Counter is one bit wider than the address so len=2^ADDR_W completes without wrapping.
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   cnt_inc;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        dout_q, dout_d;
  logic              done_q, done_d;
  logic              aborted_q, aborted_d;

  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_zero;

  ioctl_dl_timer #(
    .Width (TMR_W)
  ) u_timer (
    .clk_25     (clk_25),
    .RESET_L    (RESET_L),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  assign cnt_inc = cnt_q + CNT_ONE;

  // Next-state, counter and output-register logic for the download FSM.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    addr_d    = addr_q;
    dout_d    = dout_q;
    done_d    = 1'b0;
    aborted_d = aborted_q;
    tmr_load  = 1'b0;
    tmr_val   = '0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (len == '0) begin
            // Empty transfer: report completion without opening a window.
            done_d = 1'b1;
          end else begin
            len_d     = len;
            cnt_d     = '0;
            aborted_d = 1'b0;
            state_d   = StLead;
            tmr_load  = 1'b1;
            tmr_val   = LEAD_LOAD;
          end
        end
      end

      StLead: begin
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = StTail;
          tmr_load  = 1'b1;
          tmr_val   = TAIL_LOAD;
        end else if (tmr_zero) begin
          state_d = StFetch;
        end
      end

      StFetch: begin
        // Abort beats a byte offered in the same cycle.
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = StTail;
          tmr_load  = 1'b1;
          tmr_val   = TAIL_LOAD;
        end else if (src_valid) begin
          dout_d  = src_data;
          addr_d  = cnt_q[ADDR_W-1:0];
          state_d = StStrobe;
        end
      end

      StStrobe: begin
        cnt_d = cnt_inc;
        if (cnt_inc == len_q) begin
          state_d  = StTail;
          tmr_load = 1'b1;
          tmr_val  = TAIL_LOAD;
        end else if (GAP_CYC == 0) begin
          state_d = StFetch;
        end else begin
          state_d  = StGap;
          tmr_load = 1'b1;
          tmr_val  = GAP_LOAD;
        end
      end

      StGap: begin
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = StTail;
          tmr_load  = 1'b1;
          tmr_val   = TAIL_LOAD;
        end else if (tmr_zero) begin
          state_d = StFetch;
        end
      end

      StTail: begin
        if (tmr_zero) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers; reset drops the whole transfer at once.
  always_ff @(posedge clk_25) begin
    if (!RESET_L) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      len_q     <= '0;
      addr_q    <= '0;
      dout_q    <= '0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      addr_q    <= addr_d;
      dout_q    <= dout_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  assign src_ready      = (state_q == StFetch);
  assign ioctl_download = (state_q != StIdle);
  assign busy           = (state_q != StIdle);
  assign ioctl_wr       = (state_q == StStrobe);
  assign ioctl_addr     = addr_q;
  assign ioctl_dout     = dout_q;
  assign done           = done_q;
  assign aborted        = aborted_q;

endmodule
